// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the core's single memory port between instruction fetch and the
// load/store unit. Requests are sampled only in IDLE. A tie goes to the
// requester that was not granted last time. Load data is extracted and
// extended from the returned word. Store data is replicated across byte
// lanes and given matching byte enables. A wait counter aborts accesses
// that are never acknowledged.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr              fetch request (held until if_valid)
//   if_valid/if_instr/if_err    fetch completion pulse, word, timeout flag
//   lsu_req/we/funct3/addr/wdata
//                               load/store request (held until completion)
//   mem_read_data_valid         load completion pulse
//   mem_write_ready             store completion pulse
//   lsu_rdata/lsu_err           formatted load data, error flag
//   mem_req/we/addr/wdata/wstrb memory request (held until mem_ack)
//   mem_rdata/mem_ack           memory read word, one-cycle completion
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        if_err,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        mem_read_data_valid,
  output logic        mem_write_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

  state_t        state, state_next;
  logic          last_data;   // 1 = data path was granted most recently
  logic [CW-1:0] wait_cnt;
  logic          we_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;

  logic grant_fetch, grant_data, ack_done, expire, lsu_bad;

  // Misaligned halfword/word, undefined funct3, or an unsigned store.
  function automatic logic access_bad(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b000, 3'b100: bad = we & f3[2];
      3'b001, 3'b101: bad = off[0] | (we & f3[2]);
      3'b010:         bad = (off != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3,
                                              input logic [31:0] wdata);
    logic [31:0] lanes;
    case (f3[1:0])
      2'b00:   lanes = {4{wdata[7:0]}};
      2'b01:   lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [3:0] strb;
    case (f3[1:0])
      2'b00:   strb = 4'b0001 << off;
      2'b01:   strb = 4'b0011 << off;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Shift the addressed byte/half down to bit 0, then extend it. A legal LW
  // always has off = 0, so the shifted word is the word itself.
  function automatic logic [31:0] load_format(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b100:  res = {24'h0, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b101:  res = {16'h0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  assign lsu_bad = access_bad(lsu_we, lsu_funct3, lsu_addr[1:0]);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    ack_done    = 1'b0;
    expire      = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_req && (!if_req || !last_data)) begin
          grant_data = 1'b1;
          state_next = lsu_bad ? DONE : DATA;
        end else if (if_req) begin
          grant_fetch = 1'b1;
          state_next  = FETCH;
        end
      end
      FETCH, DATA: begin
        // An ack in the expiry cycle still completes the access normally.
        if (mem_ack) begin
          ack_done   = 1'b1;
          state_next = DONE;
        end else if (TIMEOUT != 0 && wait_cnt == CW'(TIMEOUT - 1)) begin
          expire     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every register, data registers included, has an async reset so
  // the port and pulses drop at once on rst_n and restart from known values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_data           <= 1'b0;
      wait_cnt            <= '0;
      we_q                <= 1'b0;
      funct3_q            <= 3'b000;
      off_q               <= 2'b00;
      if_valid            <= 1'b0;
      if_instr            <= '0;
      if_err              <= 1'b0;
      mem_read_data_valid <= 1'b0;
      mem_write_ready     <= 1'b0;
      lsu_rdata           <= '0;
      lsu_err             <= 1'b0;
      mem_req             <= 1'b0;
      mem_we              <= 1'b0;
      mem_addr            <= '0;
      mem_wdata           <= '0;
      mem_wstrb           <= 4'b0000;
    end else begin
      // Completion pulses last one cycle unless set again below.
      if_valid            <= 1'b0;
      mem_read_data_valid <= 1'b0;
      mem_write_ready     <= 1'b0;

      if (grant_fetch) begin
        last_data <= 1'b0;
        wait_cnt  <= '0;
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_wstrb <= 4'b0000;
        mem_addr  <= if_addr & ~32'h3;
      end

      if (grant_data) begin
        last_data <= 1'b1;
        we_q      <= lsu_we;
        funct3_q  <= lsu_funct3;
        off_q     <= lsu_addr[1:0];
        if (lsu_bad) begin
          // Rejected without touching memory; DONE follows immediately.
          lsu_err             <= 1'b1;
          lsu_rdata           <= '0;
          mem_read_data_valid <= ~lsu_we;
          mem_write_ready     <= lsu_we;
        end else begin
          wait_cnt  <= '0;
          mem_req   <= 1'b1;
          mem_we    <= lsu_we;
          mem_addr  <= lsu_addr & ~32'h3;
          mem_wdata <= lsu_we ? store_lanes(lsu_funct3, lsu_wdata) : '0;
          mem_wstrb <= lsu_we ? store_strb(lsu_funct3, lsu_addr[1:0]) : 4'b0000;
        end
      end

      if (ack_done || expire) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_wstrb <= 4'b0000;
        if (state == FETCH) begin
          if_valid <= 1'b1;
          if_err   <= expire;
          if_instr <= expire ? '0 : mem_rdata;
        end else begin
          mem_read_data_valid <= ~we_q;
          mem_write_ready     <= we_q;
          lsu_err             <= expire;
          lsu_rdata           <= (expire || we_q) ? '0
                                 : load_format(funct3_q, off_q, mem_rdata);
        end
      end else if (state == FETCH || state == DATA) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Drives fetch and load/store requesters plus a memory responder with
// random latency, and compares every grant, memory-side field, latency and
// completion result against a transaction-level reference model. The DUT
// runs with TIMEOUT = 4 so expiry, ack-on-expiry and late acks all occur.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        if_err;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        mem_read_data_valid;
  logic        mem_write_ready;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .if_req              (if_req),
    .if_addr             (if_addr),
    .if_valid            (if_valid),
    .if_instr            (if_instr),
    .if_err              (if_err),
    .lsu_req             (lsu_req),
    .lsu_we              (lsu_we),
    .lsu_funct3          (lsu_funct3),
    .lsu_addr            (lsu_addr),
    .lsu_wdata           (lsu_wdata),
    .mem_read_data_valid (mem_read_data_valid),
    .mem_write_ready     (mem_write_ready),
    .lsu_rdata           (lsu_rdata),
    .lsu_err             (lsu_err),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_wstrb           (mem_wstrb),
    .mem_rdata           (mem_rdata),
    .mem_ack             (mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: pending requests and who was granted last.
  bit f_pend   = 1'b0;
  bit d_pend   = 1'b0;
  bit m_last_d = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // {if_valid, mem_read_data_valid, mem_write_ready}
  function automatic logic [31:0] pulses();
    return {29'b0, if_valid, mem_read_data_valid, mem_write_ready};
  endfunction

  function automatic bit exp_err(input bit we, input logic [2:0] f3,
                                 input logic [31:0] addr);
    bit legal;
    logic [31:0] size;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 32'd1 << f3[1:0];
    return !legal || ((addr % size) != 32'd0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3,
                                           input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v;
    v = word >> (32'd8 * (addr % 32'd4));
    case (f3)
      3'd0: begin v = v % 32'd256;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'd4: v = v % 32'd256;
      3'd1: begin v = v % 32'd65536; if (v >= 32'd32768) v = v - 32'd65536; end
      3'd5: v = v % 32'd65536;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_strb(input logic [2:0] f3,
                                           input logic [31:0] addr);
    logic [31:0] bytes;
    bytes = 32'd1 << f3[1:0];
    return (((32'd1 << bytes) - 32'd1) << (addr % 32'd4)) & 32'hF;
  endfunction

  function automatic logic [31:0] exp_lanes(input logic [2:0] f3,
                                            input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return (wd % 32'h100) * 32'h01010101;
      2'b01:   return (wd % 32'h10000) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  // One arbitration round, entered and left at an IDLE-state negedge.
  // new_f/new_d raise a request if that requester is not already pending.
  // d is the ack delay in request cycles; d >= TO means no ack in time
  // (d == TO acks in DONE, which must be ignored).
  task automatic txn(input bit new_f, input logic [31:0] fa,
                     input bit new_d, input bit we, input logic [2:0] f3,
                     input logic [31:0] da, input logic [31:0] wd,
                     input int d, input logic [31:0] rd);
    bit          win_d, st, bad, tout;
    logic [31:0] a;
    logic [2:0]  fn;
    int          nreq, at, exp_n;

    check("idle_req", 32'(mem_req), 32'd0);
    check("idle_pulse", pulses(), 32'd0);

    if (new_f && !f_pend) begin
      f_pend = 1'b1; if_req = 1'b1; if_addr = fa;
    end
    if (new_d && !d_pend) begin
      d_pend = 1'b1; lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3;
      lsu_addr = da; lsu_wdata = wd;
    end
    if (!f_pend && !d_pend) return;

    win_d    = (f_pend && d_pend) ? !m_last_d : d_pend;
    m_last_d = win_d;
    st       = win_d && lsu_we;
    fn       = lsu_funct3;
    a        = win_d ? lsu_addr : if_addr;
    bad      = win_d && exp_err(st, fn, a);
    tout     = !bad && (d >= TO);
    exp_n    = bad ? 0 : ((d < TO) ? d + 1 : TO);

    // Occasional stray ack while IDLE: must be ignored.
    mem_ack = ($urandom_range(0, 3) == 0);
    tick();
    mem_ack = 1'b0;

    if (!bad) begin
      check("grant_req", 32'(mem_req), 32'd1);
      check("grant_addr", mem_addr, a - (a % 32'd4));
      check("grant_we", 32'(mem_we), 32'(st));
      check("grant_wstrb", 32'(mem_wstrb), st ? exp_strb(fn, a) : 32'd0);
      if (st) check("grant_wdata", mem_wdata, exp_lanes(fn, lsu_wdata));
      // Inputs changing after the grant must not matter.
      if (win_d) begin
        lsu_addr = $urandom; lsu_wdata = $urandom;
        lsu_funct3 = 3'($urandom); lsu_we = 1'($urandom);
      end else begin
        if_addr = $urandom;
      end
    end else begin
      check("err_noreq", 32'(mem_req), 32'd0);
    end

    nreq = 0;
    at   = -1;
    for (int k = 0; k < 12; k++) begin
      if (pulses() != 32'd0) begin
        at = k;
        break;
      end
      if (mem_req) nreq++;
      mem_ack   = (k == d);
      mem_rdata = (k == d) ? rd : $urandom;
      tick();
      mem_ack = 1'b0;
    end

    check("pulse_cycle", 32'(at), 32'(exp_n));
    check("req_cycles", 32'(nreq), 32'(exp_n));
    check("pulse_kind", pulses(), win_d ? (st ? 32'd1 : 32'd2) : 32'd4);
    if (win_d) begin
      check("lsu_err", 32'(lsu_err), 32'(bad || tout));
      if (!st) check("lsu_rdata", lsu_rdata,
                     (bad || tout) ? 32'd0 : exp_load(fn, a, rd));
    end else begin
      check("if_err", 32'(if_err), 32'(tout));
      check("if_instr", if_instr, tout ? 32'd0 : rd);
    end

    // Winner drops its request on the pulse; the loser stays high through
    // DONE, which must not grant it.
    if (win_d) begin d_pend = 1'b0; lsu_req = 1'b0; end
    else       begin f_pend = 1'b0; if_req  = 1'b0; end
    mem_ack = (d == TO) && !bad;
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = '0; lsu_addr = '0; lsu_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) tick();

    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_pulses", pulses(), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_err", 32'(if_err), 32'd0);
    check("rst_lsu_rdata", lsu_rdata, 32'd0);
    check("rst_lsu_err", 32'(lsu_err), 32'd0);
    rst_n = 1'b1;

    // Single fetch.
    txn(1'b1, 32'h103, 1'b0, 1'b0, 3'd0, 0, 0, 1, 32'h00A00093);

    // Load formatting against one memory word.
    txn(1'b0, 0, 1'b1, 1'b0, 3'b000, 32'h2, 0, 0, 32'h80FF7F01);
    txn(1'b0, 0, 1'b1, 1'b0, 3'b100, 32'h3, 0, 2, 32'h80FF7F01);
    txn(1'b0, 0, 1'b1, 1'b0, 3'b001, 32'h2, 0, 1, 32'h80FF7F01);
    txn(1'b0, 0, 1'b1, 1'b0, 3'b101, 32'h0, 0, 0, 32'h80FF7F01);
    txn(1'b0, 0, 1'b1, 1'b0, 3'b010, 32'h40, 0, 0, 32'h80FF7F01);

    // Stores.
    txn(1'b0, 0, 1'b1, 1'b1, 3'b000, 32'h101, 32'h000000AB, 0, 0);
    txn(1'b0, 0, 1'b1, 1'b1, 3'b001, 32'h102, 32'h00001234, 1, 0);
    txn(1'b0, 0, 1'b1, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 2, 0);

    // Rejected accesses, timeout, ack on expiry, ack after expiry.
    txn(1'b0, 0, 1'b1, 1'b0, 3'b010, 32'h102, 0, 0, 0);
    txn(1'b0, 0, 1'b1, 1'b0, 3'b011, 32'h100, 0, 0, 0);
    txn(1'b0, 0, 1'b1, 1'b1, 3'b100, 32'h100, 0, 0, 0);
    txn(1'b1, 32'h500, 1'b0, 1'b0, 3'd0, 0, 0, TO + 1, 32'h11111111);
    txn(1'b1, 32'h504, 1'b0, 1'b0, 3'd0, 0, 0, TO - 1, 32'h22222222);
    txn(1'b0, 0, 1'b1, 1'b0, 3'b010, 32'h508, 0, TO, 32'h33333333);

    // Both requesters kept busy: grants must alternate.
    for (int i = 0; i < 6; i++)
      txn(1'b1, 32'h300 + 32'(4 * i), 1'b1, 1'b0, 3'b010,
          32'h400 + 32'(4 * i), 0, i % 3, $urandom);

    // Random traffic.
    for (int i = 0; i < 150; i++)
      txn(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom,
          $urandom_range(0, TO + 1), $urandom);

    // Reset while the port is busy.
    lsu_req = 1'b0; d_pend = 1'b0;
    if_req = 1'b1; if_addr = 32'h200; f_pend = 1'b1;
    tick();
    check("rstmid_busy", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_req", 32'(mem_req), 32'd0);
    check("rstmid_pulse", pulses(), 32'd0);
    if_req = 1'b0; f_pend = 1'b0; m_last_d = 1'b0;
    repeat (3) begin
      tick();
      check("rstmid_quiet", pulses(), 32'd0);
    end
    rst_n = 1'b1;

    // First tie after reset goes to data, the next to fetch.
    txn(1'b1, 32'h600, 1'b1, 1'b0, 3'b001, 32'h702, 0, 0, 32'hA5A58001);
    txn(1'b1, 32'h604, 1'b1, 1'b1, 3'b000, 32'h703, 32'h5A, 1, 32'h0000BEEF);
    txn(1'b0, 0, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single memory port between instruction fetch and the load/store path. Formats load data (byte/half/word, signed/unsigned) and store byte-enables from funct3. Produces `mem_read_data_valid` and `mem_write_ready`, which the decode stage uses to release load/store stalls. Sits between the fetch/decode/execute logic and the external memory or bus interface.

## Interface
- `TIMEOUT`, default 255: cycles to wait for `mem_ack` before aborting. 0 disables the timeout.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request. Held with `if_addr` stable until `if_valid`.
- `if_addr` in 32: fetch address. Bits [1:0] are ignored.
- `if_valid` out 1: one-cycle pulse; `if_instr`/`if_err` are valid on it.
- `if_instr` out 32: fetched word.
- `if_err` out 1: fetch timed out.
- `lsu_req` in 1: data request. Held with `lsu_*` stable until response.
- `lsu_we` in 1: 1 = store, 0 = load.
- `lsu_funct3` in 3: RV32I load/store funct3.
- `lsu_addr` in 32: byte address.
- `lsu_wdata` in 32: store data, LSB-aligned.
- `mem_read_data_valid` out 1: one-cycle pulse that completes a load.
- `mem_write_ready` out 1: one-cycle pulse that completes a store.
- `lsu_rdata` out 32: formatted load result.
- `lsu_err` out 1: misaligned access, illegal funct3 or timeout. Valid with the completion pulse.
- `mem_req` out 1: memory request. Held until `mem_ack`.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: word address, bits [1:0] = 0.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: byte enables. 0 for reads.
- `mem_rdata` in 32: read word, valid when `mem_ack` = 1.
- `mem_ack` in 1: one-cycle completion from memory.

## Operation
- FSM states: IDLE, FETCH, DATA, DONE.
- **Reset:** state = IDLE and every output = 0, including `mem_*`, the pulses and the data registers. The last-grant pointer resets to FETCH.
- **Arbitration (IDLE only):**
  - Requests are sampled only in IDLE.
  - If one request is pending, it is granted.
  - If both are pending, the requester not granted last time wins. After reset, data therefore wins the first tie.
  - The grant registers the address, we, funct3 and wdata, then moves to FETCH or DATA.
- **Alignment check (on data grant):**
  - LH/LHU/SH with `addr[0]`=1 → error.
  - LW/SW with `addr[1:0]`≠0 → error.
  - funct3 ∈ {011, 110, 111}, or stores with funct3[2]=1 → error.
  - On error: no memory transaction; go directly to DONE with `lsu_err`=1 and `lsu_rdata`=0.
- **Memory outputs:**
  - `mem_req`=1 for the entire FETCH/DATA state.
  - `mem_addr={addr[31:2],2'b00}`.
- **Store lanes (off = `addr[1:0]`):**
  - SB: `wdata={4{wdata[7:0]}}`, `wstrb=4'b0001<<off`.
  - SH: `wdata={2{wdata[15:0]}}`, `wstrb=4'b0011<<off`.
  - SW: `wstrb=4'b1111`.
- **Load formatting:**
  - Select the byte/half at `off` from `mem_rdata`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- **Completion:**
  - `mem_ack` in FETCH/DATA → DONE.
  - Result registers capture the formatted data and the matching pulse is asserted in DONE.
- **Timeout:**
  - A counter clears on entering FETCH/DATA and increments each cycle without `mem_ack`.
  - When it reaches `TIMEOUT` (≠0): drop `mem_req`, go to DONE with err=1 and data=0.
  - `mem_ack` in the same cycle as expiry wins; the access completes normally.
- **DONE:** lasts exactly one cycle. Requests are ignored, then the FSM returns to IDLE. This lets a requester drop its `req` before IDLE resamples it.
- **Protocol errors:** `mem_ack` outside FETCH/DATA is ignored. Request inputs changing mid-transaction have no effect, because the values are registered at grant.
- **Reset mid-transaction:** `mem_req` and all pulses drop immediately (asynchronous); no completion pulse is produced.

## Timing
- Request high in IDLE at cycle N → `mem_req`=1 from N+1.
- `mem_ack` at cycle M → completion pulse plus data at M+1 (DONE) → IDLE at M+2. Earliest next `mem_req` is M+3.
- Zero-wait memory (ack in the first request cycle): total request-to-pulse latency is 2 cycles.
- Misaligned or illegal request at N → `lsu_err` pulse at N+1; `mem_req` is never asserted.
- Timeout: `mem_req` is high for `TIMEOUT` cycles; the error pulse follows in the next cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset and single fetch:** `if_req`, `if_addr`=0x103 → `mem_addr`=0x100, `wstrb`=0. `mem_ack`+`mem_rdata`=0x00A00093 two cycles later → `if_valid` pulse, `if_instr`=0x00A00093, `if_err`=0, then IDLE.
- **Load formatting:** `mem_rdata`=0x80FF7F01.
  - LB @0x2 → 0xFFFFFFFF.
  - LBU @0x3 → 0x00000080.
  - LH @0x2 → 0xFFFF80FF.
  - LHU @0x0 → 0x00007F01.
  - LW → 0x80FF7F01.
  - Each completes with a `mem_read_data_valid` pulse.
- **Stores:**
  - SB 0xAB @0x101 → `wdata`=0xABABABAB, `wstrb`=0010.
  - SH 0x1234 @0x102 → `wdata`=0x12341234, `wstrb`=1100.
  - SW → `wstrb`=1111.
  - Each completes with a `mem_write_ready` pulse.
- **Arbitration:** `if_req` and `lsu_req` held high continuously → grants alternate DATA, FETCH, DATA, ….
  - No request is granted during DONE.
  - No double grant of a request dropped on its pulse.
- **Errors:**
  - LW @0x102 → `lsu_err` pulse on the next cycle, `mem_req` never high.
  - funct3=011 → error.
  - `TIMEOUT`=4 with no ack → `mem_req` high 4 cycles, then an err pulse.
  - Ack on the expiry cycle → normal completion.
- **Reset mid-transaction:** `rst_n` low while `mem_req`=1 → `mem_req`=0 immediately, no pulse. After release, the FSM is in IDLE and the first tie is granted to DATA.
